int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 32 +++
 rtl/int_ctrl_if.sv | 12 +
 rtl/int_ctrl_irq_sync.sv | 24 ++
 rtl/int_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, pending-bit
// layout, vector-select encodings, FSM states and the source priority encoder.
package int_ctrl_pkg;

  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  localparam int PEND_TIQ  = 2;
  localparam int PEND_IRQ1 = 1;
  localparam int PEND_IRQ2 = 0;

  typedef enum logic [1:0] {
    VEC_NONE = 2'b00,
    VEC_IRQ2 = 2'b01,
    VEC_IRQ1 = 2'b10,
    VEC_TIQ  = 2'b11
  } vec_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Fixed priority TIQ > IRQ1 > IRQ2; nothing enabled yields the spurious code.
  function automatic vec_sel_e prio_sel(input logic [2:0] req);
    if (req[PEND_TIQ])       return VEC_TIQ;
    else if (req[PEND_IRQ1]) return VEC_IRQ1;
    else if (req[PEND_IRQ2]) return VEC_IRQ2;
    else                     return VEC_NONE;
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// CPU register-bus signals for the interrupt-controller page.
interface int_ctrl_if;
  logic       re;
  logic       we;
  logic       CEI_n;
  logic [1:0] addr;
  logic [7:0] dIn;
  logic [7:0] dOut;

  modport master (output re, we, CEI_n, addr, dIn, input dOut);
  modport slave  (input re, we, CEI_n, addr, dIn, output dOut);
endinterface

// File: rtl/int_ctrl_irq_sync.sv
// Two-flop synchronizer for an asynchronous active-low pin; idles deasserted (1).
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_n_i,
  output logic sync_n_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_n_i;
      sync_q <= meta_q;
    end
  end

  assign sync_n_o = sync_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: mask/status register page, registered irq_n, timer
// acknowledge pulse and a vector-latch FSM holding the serviced source.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  int_ctrl_if.slave   bus,
  input  logic        TIQ_n,
  output logic        TIQ_ack,
  input  logic        IRQ1_n,
  input  logic        IRQ2_n,
  output logic        irq_n,
  input  logic        vec_req,
  input  logic        vec_done,
  output logic [1:0]  vec_sel
);

  logic       irq1_sync_n;
  logic       irq2_sync_n;
  logic [2:0] pending;
  logic [2:0] enabled;
  logic       sel;
  logic       mask_wr;
  logic       stat_wr;

  logic [2:0] mask_q,    mask_d;
  logic       tiq_ack_q, tiq_ack_d;
  logic       irq_n_q,   irq_n_d;
  state_e     state_q,   state_d;
  vec_sel_e   vec_sel_q, vec_sel_d;

  // Synchronizers run every clk, independent of the CPU phase enable.
  irq_sync u_sync_irq1 (
    .clk       (clk),
    .reset     (reset),
    .async_n_i (IRQ1_n),
    .sync_n_o  (irq1_sync_n)
  );

  irq_sync u_sync_irq2 (
    .clk       (clk),
    .reset     (reset),
    .async_n_i (IRQ2_n),
    .sync_n_o  (irq2_sync_n)
  );

  always_comb begin
    pending            = 3'b000;
    pending[PEND_TIQ]  = ~TIQ_n;
    pending[PEND_IRQ1] = ~irq1_sync_n;
    pending[PEND_IRQ2] = ~irq2_sync_n;
  end

  assign enabled = pending & ~mask_q;
  assign sel     = ~bus.CEI_n;
  assign mask_wr = clk_en & sel & bus.we & (bus.addr == ADDR_MASK);
  assign stat_wr = clk_en & sel & bus.we & (bus.addr == ADDR_STAT);

  always_comb begin
    bus.dOut = 8'h00;
    if (sel && bus.re) begin
      case (bus.addr)
        ADDR_MASK: bus.dOut = {5'b0, mask_q};
        ADDR_STAT: bus.dOut = {5'b0, pending};
        default:   bus.dOut = 8'h00;
      endcase
    end
  end

  // Register-map and request state; everything below advances only on clk_en.
  always_comb begin
    mask_d    = mask_q;
    tiq_ack_d = tiq_ack_q;
    irq_n_d   = irq_n_q;
    if (clk_en) begin
      tiq_ack_d = stat_wr;
      irq_n_d   = ~|enabled;
      if (mask_wr) mask_d = bus.dIn[2:0];
    end
  end

  // The latch reads mask_q, so a same-cycle mask write cannot affect it.
  always_comb begin
    state_d   = state_q;
    vec_sel_d = vec_sel_q;
    if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (vec_req) begin
            state_d   = ST_HOLD;
            vec_sel_d = prio_sel(enabled);
          end
        end
        ST_HOLD: begin
          if (vec_done) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= 3'b000;
      tiq_ack_q <= 1'b0;
      irq_n_q   <= 1'b1;
      state_q   <= ST_IDLE;
      vec_sel_q <= VEC_NONE;
    end else begin
      mask_q    <= mask_d;
      tiq_ack_q <= tiq_ack_d;
      irq_n_q   <= irq_n_d;
      state_q   <= state_d;
      vec_sel_q <= vec_sel_d;
    end
  end

  assign TIQ_ack = tiq_ack_q;
  assign irq_n   = irq_n_q;
  assign vec_sel = vec_sel_q;

endmodule
